// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter family: count mode and direction encodings.
package counter_pkg;

   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;

endpackage : counter_pkg

// File: rtl/updown_next_value.sv
// Combinational next-count logic: given the current count and controls, produces the
// value an enabled count would take, whether that count hits a bound, and terminal count.
module updown_next_value
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] count,
   input  logic [WIDTH-1:0] max_value,
   input  logic             up_downbar,
   input  logic             saturate,
   output logic [WIDTH-1:0] next_count,
   output logic             boundary,
   output logic             tc
);

   logic at_top;
   logic at_bottom;

   // ">=" rather than "==" so a max_value lowered below the count still wraps/clamps.
   assign at_top    = (count >= max_value);
   assign at_bottom = (count == '0);

   always_comb begin
      next_count = count;
      boundary   = 1'b0;
      if (up_downbar == DIR_UP) begin
         if (at_top) begin
            boundary   = 1'b1;
            next_count = (saturate == MODE_SAT) ? max_value : '0;
         end else begin
            next_count = count + 1'b1;
         end
      end else begin
         if (at_bottom) begin
            boundary   = 1'b1;
            next_count = (saturate == MODE_SAT) ? '0 : max_value;
         end else begin
            next_count = count - 1'b1;
         end
      end
   end

   assign tc = (up_downbar == DIR_UP) ? at_top : at_bottom;

endmodule : updown_next_value

// File: rtl/sync_updown_counter_n.sv
// Parametrised up/down counter with run-time modulus, wrap/saturate mode, parallel load
// and a registered boundary pulse.
module sync_updown_counter_n
   import counter_pkg::*;
#(
   parameter int unsigned      WIDTH       = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             up_downbar,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic [WIDTH-1:0] max_value,
   input  logic             saturate,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             wrap
);

   logic [WIDTH-1:0] next_count;
   logic             boundary;

   // Loaded values are clamped into the legal range 0..max_value.
   function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] value,
                                                   input logic [WIDTH-1:0] limit);
      return (value > limit) ? limit : value;
   endfunction

   updown_next_value #(
      .WIDTH (WIDTH)
   ) u_next (
      .count      (out),
      .max_value  (max_value),
      .up_downbar (up_downbar),
      .saturate   (saturate),
      .next_count (next_count),
      .boundary   (boundary),
      .tc         (tc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out  <= RESET_VALUE;
         wrap <= 1'b0;
      end else if (load) begin
         out  <= clamp_load(load_value, max_value);
         wrap <= 1'b0;
      end else if (enable) begin
         out  <= next_count;
         wrap <= boundary;
      end else begin
         wrap <= 1'b0;
      end
   end

endmodule : sync_updown_counter_n

// File: tb/tb_sync_updown_counter_n.sv
// Directed bench for sync_updown_counter_n (WIDTH=4, RESET_VALUE=0) with hand-computed expectations.
module tb_sync_updown_counter_n;

   localparam int unsigned WIDTH = 4;

   logic             clk;
   logic             reset;
   logic             enable;
   logic             up_downbar;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic [WIDTH-1:0] max_value;
   logic             saturate;
   logic [WIDTH-1:0] out;
   logic             tc;
   logic             wrap;

   int checks;
   int errors;

   sync_updown_counter_n #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (4'd0)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .up_downbar (up_downbar),
      .load       (load),
      .load_value (load_value),
      .max_value  (max_value),
      .saturate   (saturate),
      .out        (out),
      .tc         (tc),
      .wrap       (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [WIDTH-1:0] value);
      load       = 1'b1;
      load_value = value;
      step();
      load       = 1'b0;
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      reset      = 1'b0;
      enable     = 1'b0;
      up_downbar = 1'b1;
      load       = 1'b0;
      load_value = '0;
      max_value  = 4'd9;
      saturate   = 1'b0;

      // Reset state
      repeat (3) step();
      check("rst_out", out, 0);
      check("rst_wrap", wrap, 0);
      check("rst_tc", tc, 0);

      // Up count, modulus 10
      reset  = 1'b1;
      enable = 1'b1;
      #1;
      for (int i = 1; i <= 12; i++) begin
         step();
         check($sformatf("up_out_%0d", i), out, i % 10);
         check($sformatf("up_wrap_%0d", i), wrap, (i == 10) ? 1 : 0);
         check($sformatf("up_tc_%0d", i), tc, ((i % 10) == 9) ? 1 : 0);
      end

      // Down count from 0 wraps to max_value
      enable = 1'b0;
      do_load(4'd0);
      check("load0_out", out, 0);
      up_downbar = 1'b0;
      enable     = 1'b1;
      #1;
      check("dn_tc_at0", tc, 1);
      step(); check("dn_out_1", out, 9); check("dn_wrap_1", wrap, 1);
      step(); check("dn_out_2", out, 8); check("dn_wrap_2", wrap, 0);
      step(); check("dn_out_3", out, 7); check("dn_wrap_3", wrap, 0);

      // Saturate mode, max 5
      enable    = 1'b0;
      saturate  = 1'b1;
      max_value = 4'd5;
      do_load(4'd0);
      up_downbar = 1'b1;
      enable     = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         check($sformatf("sat_up_out_%0d", i), out, (i < 5) ? i : 5);
         check($sformatf("sat_up_wrap_%0d", i), wrap, (i >= 6) ? 1 : 0);
      end
      up_downbar = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         step();
         check($sformatf("sat_dn_out_%0d", i), out, (i < 5) ? 5 - i : 0);
         check($sformatf("sat_dn_wrap_%0d", i), wrap, (i >= 6) ? 1 : 0);
      end
      enable = 1'b0;
      step();
      check("idle_out", out, 0);
      check("idle_wrap", wrap, 0);

      // Load clamping and load-over-enable priority
      saturate   = 1'b0;
      max_value  = 4'd9;
      up_downbar = 1'b1;
      do_load(4'd12);
      check("load_clamp", out, 9);
      check("load_clamp_wrap", wrap, 0);
      enable = 1'b1;
      do_load(4'd3);
      check("load_pri_out", out, 3);
      check("load_pri_wrap", wrap, 0);

      // Asynchronous reset mid-count
      enable = 1'b0;
      do_load(4'd7);
      check("pre_rst_out", out, 7);
      enable = 1'b1;
      #3;
      reset = 1'b0;
      #1;
      check("async_rst_out", out, 0);
      check("async_rst_wrap", wrap, 0);
      step();
      check("rst_held_out", out, 0);
      reset = 1'b1;
      step();
      check("resume_out", out, 1);

      // Full-range roll-over
      enable    = 1'b0;
      max_value = 4'd15;
      do_load(4'd14);
      enable = 1'b1;
      step(); check("roll_out_15", out, 15); check("roll_tc_15", tc, 1); check("roll_wrap_15", wrap, 0);
      step(); check("roll_out_0", out, 0); check("roll_wrap_0", wrap, 1);

      // max_value = 0
      enable    = 1'b0;
      max_value = 4'd0;
      do_load(4'd5);
      check("max0_load", out, 0);
      check("max0_tc", tc, 1);
      enable = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step();
         check($sformatf("max0_out_%0d", i), out, 0);
         check($sformatf("max0_wrap_%0d", i), wrap, 1);
      end
      up_downbar = 1'b0;
      step();
      check("max0_dn_out", out, 0);
      check("max0_dn_wrap", wrap, 1);

      // Lowering max_value below the count
      enable     = 1'b0;
      up_downbar = 1'b1;
      max_value  = 4'd9;
      do_load(4'd6);
      max_value = 4'd3;
      #1;
      check("lower_tc", tc, 1);
      enable = 1'b1;
      step();
      check("lower_up_out", out, 0);
      check("lower_up_wrap", wrap, 1);
      enable    = 1'b0;
      max_value = 4'd9;
      do_load(4'd6);
      max_value  = 4'd3;
      up_downbar = 1'b0;
      enable     = 1'b1;
      step();
      check("lower_dn_out", out, 5);
      check("lower_dn_wrap", wrap, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_sync_updown_counter_n

// File: doc/sync_updown_counter_n.md
# sync_updown_counter_n

Parametrised synchronous up/down counter: the next-generation replacement for the fixed 4-bit up/down counter. It adds configurable width, a run-time modulus, a wrap or saturate mode, parallel load, count enable, a terminal-count output and a registered wrap/limit event pulse. It serves as a general counting primitive for timers, address generators and event tallies in the Day7-style datapath blocks.

## Interface
- `WIDTH`, 4: counter width in bits; legal range 2..32.
- `RESET_VALUE`, 0: value of `out` after reset; must be ≤ 2^WIDTH−1.

- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset. Assertion is immediate. Deassertion is synchronous to `clk` by the integrating design.
- `enable`, in, 1: count enable.
- `up_downbar`, in, 1: 1 counts up, 0 counts down.
- `load`, in, 1: parallel load strobe.
- `load_value`, in, WIDTH: value for the parallel load.
- `max_value`, in, WIDTH: inclusive upper bound of the count range `0..max_value`.
- `saturate`, in, 1: 0 wraps at the bounds; 1 holds at the bounds.
- `out`, out, WIDTH: current count.
- `tc`, out, 1: terminal count, combinational. In up mode it is `out >= max_value`. In down mode it is `out == 0`.
- `wrap`, out, 1: registered one-cycle pulse when a boundary is hit on an enabled count.

## Operation
- Reset (`reset`=0): `out`=RESET_VALUE and `wrap`=0. `tc` follows from `out`. Reset mid-count abandons the count at once.
- Priority per cycle: reset, then load, then enable, then hold.
- Load (`load`=1):
  - `out` ← min(`load_value`, `max_value`).
  - `wrap` ← 0.
  - `enable` is ignored in that cycle.
- Count, up (`enable`=1, `up_downbar`=1):
  - If `out < max_value`: `out` ← `out`+1.
  - If `out >= max_value` and `saturate`=0: `out` ← 0, `wrap` ← 1.
  - If `out >= max_value` and `saturate`=1: `out` ← `max_value`, `wrap` ← 1.
- Count, down (`enable`=1, `up_downbar`=0):
  - If `out > 0`: `out` ← `out`−1. This applies even when `out > max_value`.
  - If `out == 0` and `saturate`=0: `out` ← `max_value`, `wrap` ← 1.
  - If `out == 0` and `saturate`=1: `out` stays 0, `wrap` ← 1.
- Idle (`enable`=0, `load`=0): `out` holds and `wrap` ← 0.
- `max_value`=0 is legal. `out` stays 0, `tc`=1, and every enabled count pulses `wrap`.
- `max_value` lowered below `out` at run time:
  - The next up count wraps to 0, or clamps to `max_value` when saturating.
  - Down counts decrement normally.
- Arithmetic is WIDTH-bit unsigned with no hidden carry bit. `max_value` = 2^WIDTH−1 gives plain binary roll-over.
- Direction and mode changes take effect on the next rising edge. No state is kept beyond `out` and `wrap`.

## Timing
- `out` and `wrap` are registered and update one cycle after the sampled controls.
- `tc` is combinational from `out`, `max_value` and `up_downbar`. It is valid in the same cycle, so `enable && tc` predicts a `wrap` pulse on the next edge.
- `wrap` is high for exactly one cycle per boundary event. In saturate mode with `enable` held at the bound, it stays high on every such cycle.
- Load latency is 1 cycle. Count latency is 1 cycle.

## Structure
- Shared package `counter_pkg`:
  - Mode constants `MODE_WRAP`=1'b0 and `MODE_SAT`=1'b1.
  - Direction constants `DIR_UP`=1'b1 and `DIR_DOWN`=1'b0.
- One combinational sub-module, `updown_next_value`. It is parametrised by WIDTH, takes `out`, `max_value`, `up_downbar` and `saturate`, and returns the next count, the boundary flag and `tc`. The top level holds only the reset/load/enable priority registers.

## Test plan
All scenarios use WIDTH=4 and RESET_VALUE=0.
- Reset, then up count with `max_value`=9, `saturate`=0, `enable`=1 for 12 cycles → `out` goes 1…9, 0, 1, 2. `wrap` pulses once, on the 9→0 edge. `tc`=1 while `out`=9.
- Down count from 0 with `max_value`=9, `saturate`=0 → `out` goes 9, 8, 7. `wrap` pulses on the 0→9 edge.
- Saturate: `saturate`=1, `max_value`=5, up count for 8 cycles → `out` stops at 5. `wrap` is high for each of the last 3 cycles. Switching to down reaches 0 and holds there with `wrap` high.
- Load: `load_value`=12, `max_value`=9 → `out`=9. `load` and `enable` together with `load_value`=3 → `out`=3 and no count that cycle.
- Async reset mid-count: drive `reset` low between edges at `out`=7 → `out`=0 immediately, before the next edge, and `wrap`=0. Counting resumes from 0 after release.
- Corner cases: `max_value`=15 gives 15→0 roll-over. `max_value`=0 keeps `out`=0 with `wrap` pulsing on every enabled cycle. Lowering `max_value` from 9 to 3 at `out`=6 makes the next up count 0.
